// File: rtl/reaction_session_ctrl.sv
// reaction_session_ctrl: session sequencer for the reaction game.
// Runs ROUNDS trials of random delay -> target LED -> reaction capture -> score hold,
// catches false starts, aborts and timeouts, and keeps the lowest BCD time seen.
// Every output is a flop; level outputs are decoded from the next state so they
// line up with the state register.
module reaction_session_ctrl #(
  parameter int unsigned ROUNDS      = 3,
  parameter logic [11:0] HOLD_TIME   = 12'h7FF,
  parameter logic [15:0] TIMEOUT_BCD = 16'h9999
) (
  input  logic        mclk,
  input  logic        FSMreset,
  input  logic        start_pulse,
  input  logic [9:0]  sw,
  input  logic [11:0] rand_delay,
  input  logic [9:0]  rand_led,
  input  logic        timer_done,
  input  logic [15:0] count,
  output logic        timer_load,
  output logic [11:0] timer_value,
  output logic        timer_en,
  output logic        cnt_clear,
  output logic        cnt_en,
  output logic [9:0]  led,
  output logic        disp_sel,
  output logic        score_valid,
  output logic [15:0] score_bcd,
  output logic [15:0] best_bcd,
  output logic [3:0]  round_idx,
  output logic        false_start,
  output logic        session_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_WAIT   = 3'd2,
    S_REACT  = 3'd3,
    S_RECORD = 3'd4,
    S_SHOW   = 3'd5,
    S_FALSE  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  localparam logic [3:0]  LAST_ROUND = 4'(ROUNDS - 1);
  localparam logic [15:0] BEST_INIT  = 16'h9999;

  state_t      state_q, state_d;
  logic        timer_load_q, timer_load_d;
  logic [11:0] timer_value_q, timer_value_d;
  logic        load_dly_q, load_dly_d;
  logic        timer_en_q, timer_en_d;
  logic        cnt_clear_q, cnt_clear_d;
  logic        cnt_en_q, cnt_en_d;
  logic [9:0]  led_q, led_d;
  logic        disp_sel_q, disp_sel_d;
  logic        score_valid_q, score_valid_d;
  logic [15:0] score_bcd_q, score_bcd_d;
  logic [15:0] best_bcd_q, best_bcd_d;
  logic [3:0]  round_idx_q, round_idx_d;
  logic        false_start_q, false_start_d;
  logic        session_done_q, session_done_d;

  logic [9:0]  led_keep;
  logic [15:0] result;
  logic        hit;
  logic        timeout;
  logic        timer_ok;

  // Next-state and next-output decode; outputs follow the state being entered.
  always_comb begin
    state_d       = state_q;
    timer_load_d  = 1'b0;
    timer_value_d = timer_value_q;
    score_valid_d = 1'b0;
    score_bcd_d   = score_bcd_q;
    best_bcd_d    = best_bcd_q;
    round_idx_d   = round_idx_q;
    led_keep      = led_q;
    hit           = |(sw & led_q);
    timeout       = (count == TIMEOUT_BCD);
    result        = hit ? count : TIMEOUT_BCD;
    // timer_done may still reflect the previous run while a reload is in flight,
    // so it is not trusted in the strobe cycle nor in the cycle right after it.
    timer_ok      = timer_done & ~timer_load_q & ~load_dly_q;
    load_dly_d    = timer_load_q;

    case (state_q)
      S_IDLE: begin
        if (start_pulse) begin
          best_bcd_d  = BEST_INIT;
          round_idx_d = 4'd0;
          state_d     = S_ARM;
        end
      end
      S_ARM: begin
        if (start_pulse) begin
          state_d = S_IDLE;
        end else if (sw == 10'd0) begin
          timer_load_d  = 1'b1;
          timer_value_d = rand_delay;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sw != 10'd0) begin
          timer_load_d  = 1'b1;
          timer_value_d = HOLD_TIME;
          state_d       = S_FALSE;
        end else if (start_pulse) begin
          state_d = S_IDLE;
        end else if (timer_ok) begin
          led_keep = rand_led;
          state_d  = S_REACT;
        end
      end
      S_REACT: begin
        // A hit outranks a simultaneous timeout; non-target switches do nothing.
        if (hit || timeout) begin
          score_valid_d = 1'b1;
          score_bcd_d   = result;
          if (result < best_bcd_q) begin
            best_bcd_d = result;
          end
          timer_load_d  = 1'b1;
          timer_value_d = HOLD_TIME;
          state_d       = S_RECORD;
        end
      end
      S_RECORD: begin
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (timer_ok) begin
          if (round_idx_q == LAST_ROUND) begin
            state_d = S_DONE;
          end else begin
            round_idx_d = round_idx_q + 4'd1;
            state_d     = S_ARM;
          end
        end
      end
      S_FALSE: begin
        // The round is repeated: round_idx is left alone.
        if (start_pulse) begin
          state_d = S_IDLE;
        end else if (timer_ok) begin
          state_d = S_ARM;
        end
      end
      S_DONE: begin
        if (start_pulse) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    timer_en_d     = (state_d == S_WAIT) || (state_d == S_SHOW) || (state_d == S_FALSE);
    cnt_en_d       = (state_d == S_REACT);
    cnt_clear_d    = !((state_d == S_REACT) || (state_d == S_RECORD) || (state_d == S_SHOW));
    led_d          = (state_d == S_REACT) ? led_keep : 10'd0;
    disp_sel_d     = (state_d == S_IDLE) || (state_d == S_ARM) ||
                     (state_d == S_FALSE) || (state_d == S_DONE);
    false_start_d  = (state_d == S_FALSE);
    session_done_d = (state_d == S_DONE);
  end

  // State and registered outputs; reset is asynchronous and forces the idle picture.
  always_ff @(posedge mclk or posedge FSMreset) begin
    if (FSMreset) begin
      state_q        <= S_IDLE;
      timer_load_q   <= 1'b0;
      timer_value_q  <= 12'd0;
      load_dly_q     <= 1'b0;
      timer_en_q     <= 1'b0;
      cnt_clear_q    <= 1'b1;
      cnt_en_q       <= 1'b0;
      led_q          <= 10'd0;
      disp_sel_q     <= 1'b1;
      score_valid_q  <= 1'b0;
      score_bcd_q    <= 16'h0000;
      best_bcd_q     <= BEST_INIT;
      round_idx_q    <= 4'd0;
      false_start_q  <= 1'b0;
      session_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_load_q   <= timer_load_d;
      timer_value_q  <= timer_value_d;
      load_dly_q     <= load_dly_d;
      timer_en_q     <= timer_en_d;
      cnt_clear_q    <= cnt_clear_d;
      cnt_en_q       <= cnt_en_d;
      led_q          <= led_d;
      disp_sel_q     <= disp_sel_d;
      score_valid_q  <= score_valid_d;
      score_bcd_q    <= score_bcd_d;
      best_bcd_q     <= best_bcd_d;
      round_idx_q    <= round_idx_d;
      false_start_q  <= false_start_d;
      session_done_q <= session_done_d;
    end
  end

  assign timer_load   = timer_load_q;
  assign timer_value  = timer_value_q;
  assign timer_en     = timer_en_q;
  assign cnt_clear    = cnt_clear_q;
  assign cnt_en       = cnt_en_q;
  assign led          = led_q;
  assign disp_sel     = disp_sel_q;
  assign score_valid  = score_valid_q;
  assign score_bcd    = score_bcd_q;
  assign best_bcd     = best_bcd_q;
  assign round_idx    = round_idx_q;
  assign false_start  = false_start_q;
  assign session_done = session_done_q;

endmodule

// File: tb/tb_reaction_session_ctrl.sv
// tb_reaction_session_ctrl: directed sessions with a score scoreboard.
// Stimulus pushes the expected {score_bcd, best_bcd} before each round result;
// a negedge monitor pops and compares whenever score_valid is seen.
module tb_reaction_session_ctrl;

  localparam logic [11:0] HOLD = 12'h7FF;

  logic        mclk = 1'b0;
  logic        FSMreset;
  logic        start_pulse;
  logic [9:0]  sw;
  logic [11:0] rand_delay;
  logic [9:0]  rand_led;
  logic        timer_done;
  logic [15:0] count;
  logic        timer_load;
  logic [11:0] timer_value;
  logic        timer_en;
  logic        cnt_clear;
  logic        cnt_en;
  logic [9:0]  led;
  logic        disp_sel;
  logic        score_valid;
  logic [15:0] score_bcd;
  logic [15:0] best_bcd;
  logic [3:0]  round_idx;
  logic        false_start;
  logic        session_done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int strobes   = 0;
  logic [31:0] exp_q[$];

  reaction_session_ctrl #(
    .ROUNDS(3),
    .HOLD_TIME(HOLD),
    .TIMEOUT_BCD(16'h9999)
  ) dut (
    .mclk(mclk),
    .FSMreset(FSMreset),
    .start_pulse(start_pulse),
    .sw(sw),
    .rand_delay(rand_delay),
    .rand_led(rand_led),
    .timer_done(timer_done),
    .count(count),
    .timer_load(timer_load),
    .timer_value(timer_value),
    .timer_en(timer_en),
    .cnt_clear(cnt_clear),
    .cnt_en(cnt_en),
    .led(led),
    .disp_sel(disp_sel),
    .score_valid(score_valid),
    .score_bcd(score_bcd),
    .best_bcd(best_bcd),
    .round_idx(round_idx),
    .false_start(false_start),
    .session_done(session_done)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Monitor: one line per reported round result.
  always @(negedge mclk) begin
    if (score_valid === 1'b1) begin
      logic [31:0] e;
      strobes++;
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_score: got score=%h best=%h expected no strobe", score_bcd, best_bcd);
      end else begin
        e = exp_q.pop_front();
        $display("score #%0d: score_bcd=%h best_bcd=%h", strobes, score_bcd, best_bcd);
        chk("score_bcd", {16'd0, score_bcd}, {16'd0, e[31:16]});
        chk("best_bcd", {16'd0, best_bcd}, {16'd0, e[15:0]});
      end
    end
  end

  // One round starting in ARM with sw==0; optional non-target press before the result.
  task automatic run_round(input logic [11:0] dly, input logic [9:0] ledpat,
                           input logic [9:0] pre_sw, input logic [15:0] pre_cnt,
                           input logic [9:0] hit_sw, input logic [15:0] cnt,
                           input logic [15:0] exp_best, input bit last);
    rand_delay = dly;
    tick();
    chk("wait_timer_load", {31'd0, timer_load}, 32'd1);
    chk("wait_timer_value", {20'd0, timer_value}, {20'd0, dly});
    chk("wait_timer_en", {31'd0, timer_en}, 32'd1);
    chk("wait_cnt_clear", {31'd0, cnt_clear}, 32'd1);
    chk("wait_disp_sel", {31'd0, disp_sel}, 32'd0);
    tick();
    tick();
    rand_led   = ledpat;
    timer_done = 1'b1;
    tick();
    timer_done = 1'b0;
    rand_led   = 10'b0000000001 ^ ledpat;
    chk("react_led", {22'd0, led}, {22'd0, ledpat});
    chk("react_cnt_en", {31'd0, cnt_en}, 32'd1);
    chk("react_cnt_clear", {31'd0, cnt_clear}, 32'd0);
    chk("react_timer_en", {31'd0, timer_en}, 32'd0);
    if (pre_sw != 10'd0) begin
      sw    = pre_sw;
      count = pre_cnt;
      tick();
      chk("nonmatch_stays_react", {31'd0, cnt_en}, 32'd1);
      chk("nonmatch_led_held", {22'd0, led}, {22'd0, ledpat});
    end
    sw    = hit_sw;
    count = cnt;
    exp_q.push_back({cnt, exp_best});
    tick();
    sw = 10'd0;
    chk("record_timer_load", {31'd0, timer_load}, 32'd1);
    chk("record_timer_value", {20'd0, timer_value}, {20'd0, HOLD});
    chk("record_led", {22'd0, led}, 32'd0);
    chk("record_cnt_en", {31'd0, cnt_en}, 32'd0);
    tick();
    chk("show_timer_en", {31'd0, timer_en}, 32'd1);
    chk("show_cnt_clear", {31'd0, cnt_clear}, 32'd0);
    chk("show_disp_sel", {31'd0, disp_sel}, 32'd0);
    tick();
    timer_done = 1'b1;
    tick();
    timer_done = 1'b0;
    chk("after_show_done", {31'd0, session_done}, {31'd0, last});
    chk("after_show_disp_sel", {31'd0, disp_sel}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    FSMreset = 1'b1; start_pulse = 1'b0; sw = 10'd0; rand_delay = 12'd0;
    rand_led = 10'd0; timer_done = 1'b0; count = 16'd0;
    tick();
    tick();
    chk("rst_timer_en", {31'd0, timer_en}, 32'd0);
    chk("rst_cnt_clear", {31'd0, cnt_clear}, 32'd1);
    chk("rst_disp_sel", {31'd0, disp_sel}, 32'd1);
    chk("rst_score_bcd", {16'd0, score_bcd}, 32'h0000);
    chk("rst_best_bcd", {16'd0, best_bcd}, 32'h9999);
    chk("rst_led", {22'd0, led}, 32'd0);
    FSMreset = 1'b0;
    tick();

    // Session 1: three hits with a false start repeated in the last round.
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    chk("s1_round0", {28'd0, round_idx}, 32'd0);
    run_round(12'h010, 10'b0000010000, 10'd0, 16'h0, 10'b0000010000, 16'h0250, 16'h0250, 1'b0);
    chk("s1_round1", {28'd0, round_idx}, 32'd1);
    run_round(12'h123, 10'b0010000000, 10'b0000001000, 16'h0100, 10'b0010000000, 16'h0180, 16'h0180, 1'b0);
    chk("s1_round2", {28'd0, round_idx}, 32'd2);
    tick();
    tick();
    sw = 10'b0000000100;
    tick();
    chk("fs_flag", {31'd0, false_start}, 32'd1);
    chk("fs_timer_load", {31'd0, timer_load}, 32'd1);
    chk("fs_timer_value", {20'd0, timer_value}, {20'd0, HOLD});
    tick();
    tick();
    timer_done = 1'b1;
    tick();
    timer_done = 1'b0;
    chk("fs_cleared", {31'd0, false_start}, 32'd0);
    chk("fs_round_kept", {28'd0, round_idx}, 32'd2);
    for (int i = 0; i < 3; i++) tick();
    chk("arm_stall_no_load", {31'd0, timer_load}, 32'd0);
    chk("arm_stall_timer_en", {31'd0, timer_en}, 32'd0);
    sw = 10'd0;
    run_round(12'h0AB, 10'b0000000001, 10'd0, 16'h0, 10'b0000000001, 16'h0300, 16'h0180, 1'b1);
    chk("s1_done_best", {16'd0, best_bcd}, 32'h0180);

    // Session 2: hit, timeout with non-target press, then abort in WAIT.
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    chk("done_to_idle", {31'd0, session_done}, 32'd0);
    chk("idle_best_kept", {16'd0, best_bcd}, 32'h0180);
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    chk("s2_best_init", {16'd0, best_bcd}, 32'h9999);
    chk("s2_round0", {28'd0, round_idx}, 32'd0);
    run_round(12'h055, 10'b1000000000, 10'd0, 16'h0, 10'b1000000000, 16'h0420, 16'h0420, 1'b0);
    run_round(12'h066, 10'b0010000000, 10'b0000001000, 16'h0555, 10'b0000001000, 16'h9999, 16'h0420, 1'b0);
    tick();
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    chk("abort_timer_en", {31'd0, timer_en}, 32'd0);
    chk("abort_cnt_clear", {31'd0, cnt_clear}, 32'd1);
    chk("abort_best_kept", {16'd0, best_bcd}, 32'h0420);
    chk("abort_no_false_start", {31'd0, false_start}, 32'd0);

    // Session 3: one hit, then asynchronous reset in REACT of the next round.
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    run_round(12'h077, 10'b0000100000, 10'd0, 16'h0, 10'b0000100000, 16'h0111, 16'h0111, 1'b0);
    tick();
    tick();
    tick();
    rand_led   = 10'b0000100000;
    timer_done = 1'b1;
    tick();
    timer_done = 1'b0;
    chk("s3_in_react", {31'd0, cnt_en}, 32'd1);
    #2 FSMreset = 1'b1;
    #1;
    chk("arst_led", {22'd0, led}, 32'd0);
    chk("arst_cnt_en", {31'd0, cnt_en}, 32'd0);
    chk("arst_best", {16'd0, best_bcd}, 32'h9999);
    chk("arst_round", {28'd0, round_idx}, 32'd0);
    chk("arst_cnt_clear", {31'd0, cnt_clear}, 32'd1);
    tick();
    FSMreset = 1'b0;
    tick();
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    chk("new_session_round", {28'd0, round_idx}, 32'd0);
    tick();
    chk("new_session_load", {31'd0, timer_load}, 32'd1);
    tick();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("strobe_total", strobes, 32'd6);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reaction_session_ctrl.md
Name: reaction_session_ctrl

Overview:
- Sequences the reaction-game datapath (random delay timer, BCD reaction counter, one-hot LED target, top-score register) through a multi-round session of ROUNDS trials.
- Detects false starts, aborts and timeouts, and reports the best (lowest) BCD reaction time of the session.
- Sits between the KEY0 pulse generator / LFSR / LED shuffler and the delay timer, BCD counter and top-score modules in the top level.

Parameters:
- ROUNDS, 3, trials per session (1..15).
- HOLD_TIME, 12'h7FF, delay-timer reload value for the per-round score display.
- TIMEOUT_BCD, 16'h9999, BCD count at which a round ends as a miss.

Ports:
- mclk  in  1  system clock (divided clock); all logic on its rising edge.
- FSMreset  in  1  asynchronous, active-high reset.
- start_pulse  in  1  one-cycle KEY0 press pulse.
- sw  in  10  slide switches.
- rand_delay  in  12  LFSR random delay value.
- rand_led  in  10  free-running one-hot LED pattern.
- timer_done  in  1  delay timer expired (level).
- count  in  16  BCD reaction count (4 digits).
- timer_load  out  1  one-cycle load strobe for the delay timer.
- timer_value  out  12  value loaded on timer_load.
- timer_en  out  1  delay timer count enable.
- cnt_clear  out  1  hold BCD counter at 0000.
- cnt_en  out  1  BCD counter count enable.
- led  out  10  target LED (one-hot or zero).
- disp_sel  out  1  0 = show live count, 1 = show best_bcd.
- score_valid  out  1  one-cycle strobe; round result on score_bcd.
- score_bcd  out  16  last round result.
- best_bcd  out  16  session best; feeds the top-score module.
- round_idx  out  4  current round number, 0-based.
- false_start  out  1  high while the false-start/abort indication is shown.
- session_done  out  1  high in DONE.

Behaviour:
- Reset values: state IDLE; all strobes 0; timer_en 0, cnt_en 0, cnt_clear 1; led 0; disp_sel 1; score_bcd 0000; best_bcd 16'h9999; round_idx 0; false_start 0; session_done 0.
- BCD compare: plain unsigned 16-bit compare (valid BCD preserves numeric order).

State machine:
- IDLE: cnt_clear=1, disp_sel=1. On start_pulse: best_bcd←9999, round_idx←0, false_start←0, go to ARM.
- ARM: waits until sw==0.
  - Then pulses timer_load for 1 cycle with timer_value=rand_delay, latched that cycle, and goes to WAIT.
  - start_pulse in ARM → IDLE.
- WAIT: timer_en=1, cnt_clear=1, led=0, disp_sel=0.
  - timer_done is ignored in the first cycle after timer_load.
  - Priority, highest first:
    1. sw!=0 → FALSE (false start).
    2. start_pulse → IDLE (abort; best_bcd unchanged, false_start not set).
    3. timer_done → REACT. On this transition, latch led←rand_led and set cnt_clear=0.
- REACT: cnt_en=1, timer_en=0, led held.
  - (sw & led)!=0 → RECORD with result=count.
  - Else if count==TIMEOUT_BCD → RECORD with result=TIMEOUT_BCD.
  - A switch that does not match the target is ignored. Both conditions in the same cycle → hit wins.
- RECORD: exactly 1 cycle.
  - score_bcd←result; score_valid=1.
  - If result<best_bcd then best_bcd←result.
  - cnt_en=0, led←0.
  - timer_load with HOLD_TIME; go to SHOW.
- SHOW: timer_en=1, disp_sel=0, counter frozen (cnt_en=0, cnt_clear=0).
  - On timer_done (not in first cycle after load): if round_idx==ROUNDS-1 → DONE; else round_idx←round_idx+1, cnt_clear=1, → ARM.
- FALSE: false_start=1.
  - Loads HOLD_TIME on entry, timer_en=1.
  - On timer_done → ARM with round_idx unchanged (the round is repeated).
  - start_pulse → IDLE.
- DONE: session_done=1, disp_sel=1, led=0, best_bcd held. start_pulse → IDLE.
- Reset mid-operation: returns to the reset values within the same cycle (async), regardless of state.
- Illegal state encoding → IDLE.

Test Plan:
- ROUNDS=1. start_pulse, rand_delay=12'h010, timer expires, rand_led=10'b0000010000; raise sw[4] at count=0123 → score_valid one cycle with score_bcd=0123, best_bcd=0123; after HOLD_TIME expiry: session_done=1, disp_sel=1.
- ROUNDS=3 with hits at 0250, 0180, 0300 → three score_valid strobes; round_idx steps 0→1→2; final best_bcd=0180.
- sw[2]=1 during WAIT → false_start=1, no score_valid; after hold, returns to ARM with round_idx unchanged; ARM stalls until sw==0.
- In REACT with target LED 7, raise sw[3] only → no transition; count reaches 9999 → score_bcd=9999, best_bcd stays 9999.
- start_pulse in WAIT → IDLE; timer_en=0, cnt_clear=1, best_bcd unchanged.
- Assert FSMreset during REACT → same cycle: led=0, cnt_en=0, best_bcd=9999, state IDLE; next start_pulse begins a new session at round 0.
